// File: rtl/simd_pkg.sv
// Shared definitions for the packed-nibble SIMD path: FSM state encoding,
// lane geometry, saturation constants and the single-lane saturating add.
package simd_pkg;

    localparam int LANES  = 4;
    localparam int LANE_W = 4;
    localparam int DATA_W = LANES * LANE_W;

    localparam logic [LANE_W-1:0] SAT_POS = 4'h7;
    localparam logic [LANE_W-1:0] SAT_NEG = 4'h8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        DONE = 2'd2
    } state_t;

    typedef struct packed {
        logic              sat;
        logic [LANE_W-1:0] val;
    } lane_res_t;

    // Two's-complement add of one lane, clamped to the lane range on overflow.
    // Overflow is only possible when both operands share a sign and the
    // wrapped sum comes out with the opposite sign.
    function automatic lane_res_t lane_add(input logic [LANE_W-1:0] a,
                                           input logic [LANE_W-1:0] b);
        lane_res_t         r;
        logic [LANE_W-1:0] s;
        s     = a + b;
        r.sat = 1'b0;
        r.val = s;
        if (!a[LANE_W-1] && !b[LANE_W-1] && s[LANE_W-1]) begin
            r.sat = 1'b1;
            r.val = SAT_POS;
        end else if (a[LANE_W-1] && b[LANE_W-1] && !s[LANE_W-1]) begin
            r.sat = 1'b1;
            r.val = SAT_NEG;
        end
        return r;
    endfunction

endpackage

// File: rtl/nibble_sat_add.sv
// Combinational 4-lane saturating adder. Each 4-bit signed lane is added
// independently; no carry crosses a lane boundary.
module nibble_sat_add
    import simd_pkg::*;
(
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic [DATA_W-1:0] sum,
    output logic [LANES-1:0]  lane_sat
);

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        lane_res_t res;
        assign res                          = lane_add(a[i*LANE_W +: LANE_W], b[i*LANE_W +: LANE_W]);
        assign sum[i*LANE_W +: LANE_W]      = res.val;
        assign lane_sat[i]                  = res.sat;
    end

endmodule

// File: rtl/sat_accum_ctrl.sv
// Burst sequencer around the nibble saturating adder: takes a start command
// with an operand count, accumulates that many operands from a valid/ready
// stream, then holds the saturated sum on a valid/ready result port.
// Optional feature: define SAT_STICKY_EN to add the per-lane sticky
// saturation flags output (sat_flags).
module sat_accum_ctrl
    import simd_pkg::*;
#(
    parameter int LEN_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [LEN_W-1:0]  len,
    input  logic              abort,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    input  logic              out_ready,
    output logic              busy
`ifdef SAT_STICKY_EN
    ,
    output logic [LANES-1:0]  sat_flags
`endif
);

    state_t            state_q;
    state_t            state_d;
    logic [DATA_W-1:0] acc_q;
    logic [LEN_W-1:0]  cnt_q;
    logic [DATA_W-1:0] add_sum;
    logic [LANES-1:0]  lane_sat;
    logic              start_go;
    logic              acc_fire;

    // start is honoured only in IDLE; an operand is absorbed only when no
    // abort is present, since abort wins over a simultaneous handshake.
    assign start_go = (state_q == IDLE) && start;
    assign acc_fire = (state_q == ACC) && in_valid && !abort;

    nibble_sat_add u_add (
        .a        (acc_q),
        .b        (in_data),
        .sum      (add_sum),
        .lane_sat (lane_sat)
    );

    // All handshake outputs are pure state decodes; the result is the accumulator.
    assign in_ready  = (state_q == ACC);
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q != IDLE);
    assign out_data  = acc_q;

    // State register.
    // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Next-state decode.
    // NOTE: state_d gets a default first so no path through the case infers a latch.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (start) state_d = (len != '0) ? ACC : DONE;
            end
            ACC: begin
                if (abort)                                   state_d = IDLE;
                else if (in_valid && cnt_q == LEN_W'(1))     state_d = DONE;
            end
            DONE: begin
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Accumulator and remaining-operand counter; cleared on an accepted start.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q <= '0;
            cnt_q <= '0;
        end else if (start_go) begin
            acc_q <= '0;
            cnt_q <= len;
        end else if (acc_fire) begin
            acc_q <= add_sum;
            cnt_q <= cnt_q - LEN_W'(1);
        end
    end

`ifdef SAT_STICKY_EN
    logic [LANES-1:0] sat_q;

    // Sticky per-lane saturation, cleared when a new burst is accepted.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)           sat_q <= '0;
        else if (start_go) sat_q <= '0;
        else if (acc_fire) sat_q <= sat_q | lane_sat;
    end

    assign sat_flags = sat_q;
`else
    logic unused_lane_sat;
    assign unused_lane_sat = ^lane_sat;
`endif

endmodule

// File: tb/tb_sat_accum_ctrl.sv
// Directed self-checking bench for sat_accum_ctrl. Inputs change and outputs
// are sampled on the falling edge; the DUT acts on the rising edge.
module tb_sat_accum_ctrl;

    logic        clk;
    logic        rst;
    logic        start;
    logic [7:0]  len;
    logic        abort;
    logic        in_valid;
    logic [15:0] in_data;
    logic        in_ready;
    logic        out_valid;
    logic [15:0] out_data;
    logic        out_ready;
    logic        busy;
`ifdef SAT_STICKY_EN
    logic [3:0]  sat_flags;
`endif

    int n_cmp = 0;
    int n_err = 0;

    sat_accum_ctrl #(.LEN_W(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .len       (len),
        .abort     (abort),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready),
        .busy      (busy)
`ifdef SAT_STICKY_EN
        ,
        .sat_flags (sat_flags)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed no finish, expected finish before 200000");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic start_burst(input logic [7:0] n);
        start = 1'b1;
        len   = n;
        tick();
        start = 1'b0;
        len   = 8'd0;
    endtask

    // Present one operand and hold it until it is accepted (bounded).
    task automatic send(input string tag, input logic [15:0] d);
        in_valid = 1'b1;
        in_data  = d;
        for (int i = 0; i < 20 && !in_ready; i++) tick();
        check(tag, 16'(in_ready), 16'h0001);
        tick();
        in_valid = 1'b0;
        in_data  = 16'h0000;
    endtask

    // Wait (bounded) for the result, check it, then consume it.
    task automatic take_result(input string tag, input logic [15:0] exp_data,
                               input logic [3:0] exp_flags);
        for (int i = 0; i < 20 && !out_valid; i++) tick();
        check({tag, "_valid"}, 16'(out_valid), 16'h0001);
        check({tag, "_data"}, out_data, exp_data);
        check({tag, "_in_ready"}, 16'(in_ready), 16'h0000);
`ifdef SAT_STICKY_EN
        check({tag, "_flags"}, 16'(sat_flags), 16'(exp_flags));
`else
        if (exp_flags === 4'hx) $display("unreachable");
`endif
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check({tag, "_done_valid"}, 16'(out_valid), 16'h0000);
        check({tag, "_done_busy"}, 16'(busy), 16'h0000);
    endtask

    initial begin
        rst       = 1'b1;
        start     = 1'b0;
        len       = 8'd0;
        abort     = 1'b0;
        in_valid  = 1'b0;
        in_data   = 16'h0000;
        out_ready = 1'b0;
        repeat (3) tick();

        // Reset state.
        check("rst_in_ready", 16'(in_ready), 16'h0000);
        check("rst_out_valid", 16'(out_valid), 16'h0000);
        check("rst_busy", 16'(busy), 16'h0000);
        check("rst_out_data", out_data, 16'h0000);
`ifdef SAT_STICKY_EN
        check("rst_flags", 16'(sat_flags), 16'h0000);
`endif
        rst = 1'b0;
        tick();
        check("idle_busy", 16'(busy), 16'h0000);

        // 1: positive saturation in every lane, result one cycle after last beat.
        start_burst(8'd2);
        check("t1_busy", 16'(busy), 16'h0001);
        check("t1_in_ready", 16'(in_ready), 16'h0001);
        send("t1_beat0", 16'h7777);
        check("t1_mid_data", out_data, 16'h7777);
        send("t1_beat1", 16'h1111);
        check("t1_latency", 16'(out_valid), 16'h0001);
        take_result("t1", 16'h7777, 4'hF);

        // 2: back-to-back start right after the result handshake; no saturation.
        start_burst(8'd3);
        check("t2_busy", 16'(busy), 16'h0001);
        send("t2_beat0", 16'h1234);
        send("t2_beat1", 16'h1111);
        check("t2_not_done", 16'(out_valid), 16'h0000);
        send("t2_beat2", 16'hF0F0);
        take_result("t2", 16'h1335, 4'h0);

        // 3: negative saturation in every lane.
        start_burst(8'd2);
        send("t3_beat0", 16'h8888);
        send("t3_beat1", 16'h8888);
        take_result("t3", 16'h8888, 4'hF);

        // 4: zero-length burst goes straight to DONE with a cleared accumulator.
        start_burst(8'd0);
        check("t4_valid_next", 16'(out_valid), 16'h0001);
        check("t4_in_ready", 16'(in_ready), 16'h0000);
        take_result("t4", 16'h0000, 4'h0);

        // 5: gaps on the operand stream, then a stalled result with start ignored.
        start_burst(8'd3);
        send("t5_beat0", 16'h1111);
        tick();
        tick();
        check("t5_gap_ready", 16'(in_ready), 16'h0001);
        check("t5_gap_valid", 16'(out_valid), 16'h0000);
        send("t5_beat1", 16'h2222);
        tick();
        send("t5_beat2", 16'h3333);
        start = 1'b1;
        len   = 8'd5;
        for (int i = 0; i < 3; i++) begin
            check("t5_stall_valid", 16'(out_valid), 16'h0001);
            check("t5_stall_data", out_data, 16'h6666);
            check("t5_stall_ready", 16'(in_ready), 16'h0000);
            check("t5_stall_busy", 16'(busy), 16'h0001);
            tick();
        end
        start = 1'b0;
        len   = 8'd0;
        take_result("t5", 16'h6666, 4'h0);
        tick();
        check("t5_idle_stays", 16'(busy), 16'h0000);

        // 6a: abort on the second beat drops it and returns to IDLE.
        start_burst(8'd3);
        send("t6_beat0", 16'h1111);
        in_valid = 1'b1;
        in_data  = 16'h2222;
        abort    = 1'b1;
        check("t6_abort_ready", 16'(in_ready), 16'h0001);
        tick();
        in_valid = 1'b0;
        abort    = 1'b0;
        check("t6_abort_busy", 16'(busy), 16'h0000);
        check("t6_abort_valid", 16'(out_valid), 16'h0000);
        repeat (3) tick();
        check("t6_no_result", 16'(out_valid), 16'h0000);

        // 6b: reset mid-burst clears everything without waiting for a clock edge.
        start_burst(8'd3);
        send("t6b_beat0", 16'h7777);
        send("t6b_beat1", 16'h1111);
        check("t6b_pre_busy", 16'(busy), 16'h0001);
        #1 rst = 1'b1;
        #1;
        check("t6b_rst_busy", 16'(busy), 16'h0000);
        check("t6b_rst_in_ready", 16'(in_ready), 16'h0000);
        check("t6b_rst_out_valid", 16'(out_valid), 16'h0000);
        check("t6b_rst_out_data", out_data, 16'h0000);
`ifdef SAT_STICKY_EN
        check("t6b_rst_flags", 16'(sat_flags), 16'h0000);
`endif
        tick();
        rst = 1'b0;
        tick();

        // A fresh burst after reset starts from a clean accumulator.
        start_burst(8'd1);
        send("t7_beat0", 16'h0102);
        take_result("t7", 16'h0102, 4'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
